// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply / divide unit for the pipeline's DX stage.
// Multiply: radix-2 shift-add on magnitudes. Divide: restoring division on
// magnitudes. Both take 32 iteration edges plus one finalize edge. On the
// finalize edge the result is published with a one-cycle data_resultRDY pulse.
module multdiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  tag_in,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic [4:0]  tag_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    logic [5:0]  cnt_r;
    logic [4:0]  tag_r;
    logic        neg_r;       // result sign = signA ^ signB
    logic        div_zero_r;  // divisor was zero
    logic        div_ovf_r;   // 0x80000000 / -1
    logic [63:0] acc_r;       // product accumulator
    logic [63:0] mcand_r;     // multiplicand magnitude, shifts left
    logic [31:0] mplier_r;    // multiplier magnitude, shifts right
    logic [31:0] rem_r;       // partial remainder
    logic [31:0] quo_r;       // dividend bits shift out, quotient bits shift in
    logic [31:0] dvs_r;       // divisor magnitude

    logic        start_s;
    logic [32:0] div_shift_s;
    logic [32:0] div_diff_s;
    logic        div_ge_s;
    logic [63:0] prod_signed_s;
    logic        mult_exc_s;
    logic [31:0] quo_signed_s;

    // Two's-complement magnitude; 0x80000000 maps to 2^31, which fits unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (~v + 32'd1) : v;
    endfunction

    // Exactly one strobe starts an operation; both high is treated as no strobe.
    assign start_s = ctrl_MULT ^ ctrl_DIV;

    // Divide step datapath and finalize-time sign/exception logic.
    always_comb begin
        div_shift_s   = {rem_r, quo_r[31]};
        div_diff_s    = div_shift_s - {1'b0, dvs_r};
        div_ge_s      = (div_shift_s >= {1'b0, dvs_r});
        prod_signed_s = neg_r ? (~acc_r + 64'd1) : acc_r;
        mult_exc_s    = (prod_signed_s[63:31] != {33{prod_signed_s[31]}});
        quo_signed_s  = neg_r ? (~quo_r + 32'd1) : quo_r;
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= 6'd0;
            tag_r          <= 5'd0;
            neg_r          <= 1'b0;
            div_zero_r     <= 1'b0;
            div_ovf_r      <= 1'b0;
            acc_r          <= 64'd0;
            mcand_r        <= 64'd0;
            mplier_r       <= 32'd0;
            rem_r          <= 32'd0;
            quo_r          <= 32'd0;
            dvs_r          <= 32'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            tag_out        <= 5'd0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start_s) begin
                // A start edge aborts anything in flight without a RDY pulse.
                state_r    <= ctrl_MULT ? MULT : DIV;
                cnt_r      <= 6'd0;
                tag_r      <= tag_in;
                neg_r      <= data_operandA[31] ^ data_operandB[31];
                div_zero_r <= (data_operandB == 32'd0);
                div_ovf_r  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
                acc_r      <= 64'd0;
                mcand_r    <= {32'd0, abs32(data_operandA)};
                mplier_r   <= abs32(data_operandB);
                rem_r      <= 32'd0;
                quo_r      <= abs32(data_operandA);
                dvs_r      <= abs32(data_operandB);
                busy       <= 1'b1;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    MULT: begin
                        if (cnt_r == 6'd32) begin
                            data_result    <= prod_signed_s[31:0];
                            data_exception <= mult_exc_s;
                            tag_out        <= tag_r;
                            data_resultRDY <= 1'b1;
                            busy           <= 1'b0;
                            state_r        <= DONE;
                        end else begin
                            if (mplier_r[0]) begin
                                acc_r <= acc_r + mcand_r;
                            end else begin
                                acc_r <= acc_r;
                            end
                            mcand_r  <= {mcand_r[62:0], 1'b0};
                            mplier_r <= {1'b0, mplier_r[31:1]};
                            cnt_r    <= cnt_r + 6'd1;
                        end
                    end
                    DIV: begin
                        if (cnt_r == 6'd32) begin
                            if (div_zero_r) begin
                                data_result    <= 32'd0;
                                data_exception <= 1'b1;
                            end else if (div_ovf_r) begin
                                data_result    <= 32'h8000_0000;
                                data_exception <= 1'b1;
                            end else begin
                                data_result    <= quo_signed_s;
                                data_exception <= 1'b0;
                            end
                            tag_out        <= tag_r;
                            data_resultRDY <= 1'b1;
                            busy           <= 1'b0;
                            state_r        <= DONE;
                        end else begin
                            if (div_ge_s) begin
                                rem_r <= div_diff_s[31:0];
                                quo_r <= {quo_r[30:0], 1'b1};
                            end else begin
                                rem_r <= div_shift_s[31:0];
                                quo_r <= {quo_r[30:0], 1'b0};
                            end
                            cnt_r <= cnt_r + 6'd1;
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit with an expected-result scoreboard queue.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [4:0]  tag_in = 5'd0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [4:0]  tag_out;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_cnt = 0;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .tag_in         (tag_in),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .tag_out        (tag_out),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Count every RDY pulse, sampled mid-cycle.
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) rdy_cnt++;
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic exp_t model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] tag);
        exp_t e;
        longint p;
        e.tag = tag;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            e.res = $signed(a) / $signed(b);
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Wait (bounded) for the RDY pulse, check latency, then compare against the queue head.
    task automatic wait_rdy(input string name);
        int   lat = 0;
        exp_t e;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY === 1'b1) begin
                lat = i;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'd33);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (lat != 0) begin
                check({name, "_result"}, 64'(data_result), 64'(e.res));
                check({name, "_exc"}, 64'(data_exception), 64'(e.exc));
                check({name, "_tag"}, 64'(tag_out), 64'(e.tag));
                check({name, "_busy_done"}, 64'(busy), 64'd0);
                @(posedge clock); #1;
                check({name, "_rdy_drop"}, 64'(data_resultRDY), 64'd0);
                check({name, "_result_hold"}, 64'(data_result), 64'(e.res));
            end
        end
    endtask

    // Drive a start strobe for 'hold' edges and push the expected result.
    task automatic run_op(input string name, input bit is_mult, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input int hold);
        @(negedge clock);
        ctrl_MULT = is_mult;
        ctrl_DIV = !is_mult;
        data_operandA = a;
        data_operandB = b;
        tag_in = tag;
        repeat (hold) @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        check({name, "_busy_start"}, 64'(busy), 64'd1);
        sb.push_back(model(is_mult, a, b, tag));
        wait_rdy(name);
    endtask

    initial begin
        int c0;
        logic [31:0] saved_res;
        logic [4:0]  saved_tag;

        // Reset state
        #1;
        check("rst_result", 64'(data_result), 64'd0);
        check("rst_exc", 64'(data_exception), 64'd0);
        check("rst_rdy", 64'(data_resultRDY), 64'd0);
        check("rst_tag", 64'(tag_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Directed operations, including spec constants
        run_op("mul_7xm3", 1'b1, 32'd7, 32'hFFFF_FFFD, 5'd5, 1);
        check("mul_7xm3_const", 64'(data_result), 64'hFFFF_FFEB);
        run_op("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000, 5'd9, 1);
        check("mul_ovf_const", 64'(data_exception), 64'd1);
        run_op("div_m100_7", 1'b0, 32'hFFFF_FF9C, 32'd7, 5'd3, 1);
        check("div_m100_7_const", 64'(data_result), 64'hFFFF_FFF2);
        run_op("div_by0", 1'b0, 32'd5, 32'd0, 5'd12, 1);
        run_op("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 1);
        run_op("mul_minxm1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 1);
        run_op("mul_negneg", 1'b1, 32'hFFFF_F000, 32'hFFFF_FFF0, 5'd7, 1);
        run_op("div_negneg", 1'b0, 32'h8000_0000, 32'hFFFF_FFF9, 5'd20, 1);
        run_op("mul_held", 1'b1, 32'd12345, 32'd678, 5'd14, 3);

        // Abort: MULT 3x4, DIV 100/10 started 10 edges later
        c0 = rdy_cnt;
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        tag_in = 5'd2;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (9) @(posedge clock);
        run_op("abort_div", 1'b0, 32'd100, 32'd10, 5'd6, 1);
        check("abort_div_const", 64'(data_result), 64'd10);
        repeat (40) @(posedge clock);
        check("abort_one_rdy", 64'(rdy_cnt - c0), 64'd1);

        // Both strobes from IDLE are ignored
        saved_res = data_result;
        saved_tag = tag_out;
        c0 = rdy_cnt;
        @(negedge clock);
        ctrl_MULT = 1'b1;
        ctrl_DIV = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        tag_in = 5'd17;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        check("both_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clock);
        #1;
        check("both_no_rdy", 64'(rdy_cnt - c0), 64'd0);
        check("both_result_hold", 64'(data_result), 64'(saved_res));
        check("both_tag_hold", 64'(tag_out), 64'(saved_tag));

        // Asynchronous reset mid-cycle after 15 edges of a MULT
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd21;
        data_operandB = 32'd2;
        tag_in = 5'd11;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (15) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("areset_result", 64'(data_result), 64'd0);
        check("areset_tag", 64'(tag_out), 64'd0);
        check("areset_busy", 64'(busy), 64'd0);
        check("areset_exc", 64'(data_exception), 64'd0);
        check("areset_rdy", 64'(data_resultRDY), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        c0 = rdy_cnt;
        repeat (40) @(posedge clock);
        #1;
        check("areset_no_rdy", 64'(rdy_cnt - c0), 64'd0);

        // Unit still works after reset
        run_op("post_reset_div", 1'b0, 32'd1000, 32'hFFFF_FFFD, 5'd8, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
